// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package inst_fetch_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;
    localparam int STALL_W     = 6;

    localparam logic [INST_W-1:0] ZERO_WORD = 32'h0000_0000;
    localparam logic              NO_STOP   = 1'b0;

    // Fetch FSM states.
    typedef enum logic [1:0] {
        IF_LOOKUP = 2'd0,
        IF_FETCH  = 2'd1,
        IF_HOLD   = 2'd2
    } if_state_e;

    // Instructions are word aligned; the low two bits of any redirect target are dropped.
    function automatic logic [INST_ADDR_W-1:0] word_align(input logic [INST_ADDR_W-1:0] addr);
        return {addr[INST_ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_icache.sv
// Direct-mapped instruction cache, one 32-bit instruction per line.
// Lookup is combinational; a line write and the valid-bit clear are synchronous.
module inst_fetch_icache
    import inst_fetch_pkg::*;
#(
    parameter  int LINES = 64,
    localparam int IDX_W = $clog2(LINES),
    localparam int TAG_W = INST_ADDR_W - 2 - IDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [TAG_W-1:0]  tag_i,
    output logic              hit_o,
    output logic [INST_W-1:0] rd_data_o,
    input  logic              wr_en_i,
    input  logic [INST_W-1:0] wr_data_i
);

    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] line_sel;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [INST_W-1:0] data_mem [LINES];

    // One-hot decode of the addressed line, used to set its valid bit.
    for (genvar gi = 0; gi < LINES; gi++) begin : g_line_sel
        assign line_sel[gi] = (idx_i == IDX_W'(gi));
    end

    // Valid bits: cleared by reset only, set when a line is filled.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q <= valid_q | line_sel;
        end
    end

    // Tag and data arrays carry no reset; the valid bit qualifies them.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_mem[idx_i]  <= tag_i;
            data_mem[idx_i] <= wr_data_i;
        end
    end

    assign hit_o     = valid_q[idx_i] && (tag_mem[idx_i] == tag_i);
    assign rd_data_o = data_mem[idx_i];

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: PC, cache lookup, byte-wise refill on a miss,
// and a one-entry hand-off to the IF/ID register with stall and redirect.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int                     ICACHE_LINES = 64,
    parameter logic [INST_ADDR_W-1:0] RESET_PC     = 32'h0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [STALL_W-1:0]     stall_i,
    input  logic                   br_flag_i,
    input  logic [INST_ADDR_W-1:0] br_target_i,
    input  logic                   mem_gnt_i,
    input  logic                   mem_rvalid_i,
    input  logic [7:0]             mem_rdata_i,
    output logic                   mem_req_o,
    output logic [INST_ADDR_W-1:0] mem_addr_o,
    output logic                   if_flag_o,
    output logic                   if_first_o,
    output logic [INST_ADDR_W-1:0] if_pc_o,
    output logic [INST_W-1:0]      if_inst_o
);

    localparam int IDX_W = $clog2(ICACHE_LINES);
    localparam int TAG_W = INST_ADDR_W - 2 - IDX_W;

    if_state_e              state_q;
    logic [INST_ADDR_W-1:0] pc_q;
    logic                   first_q;
    logic [2:0]             req_cnt_q;
    logic [2:0]             rcv_cnt_q;
    logic [INST_W-1:0]      buf_q;
    logic                   mem_req_q;
    logic [INST_ADDR_W-1:0] mem_addr_q;
    logic                   if_flag_q;
    logic                   if_first_q;
    logic [INST_ADDR_W-1:0] if_pc_q;
    logic [INST_W-1:0]      if_inst_q;

    logic              cache_hit;
    logic [INST_W-1:0] cache_data;
    logic [INST_W-1:0] word_d;
    logic              transfer;
    logic              last_byte;
    logic              cache_wr_en;
    logic              unused_inputs;

    assign transfer    = if_flag_q && (stall_i[1] == NO_STOP);
    assign last_byte   = (state_q == IF_FETCH) && mem_rvalid_i && (rcv_cnt_q == 3'd3);
    // A redirect or reset in the completing cycle abandons the refill.
    assign cache_wr_en = last_byte && !br_flag_i && !rst;
    // Only stall[1] concerns this stage; target bits [1:0] are always replaced by zero.
    assign unused_inputs = ^{stall_i[STALL_W-1:2], stall_i[0], br_target_i[1:0]};

    inst_fetch_icache #(
        .LINES (ICACHE_LINES)
    ) u_icache (
        .clk       (clk),
        .rst       (rst),
        .idx_i     (pc_q[2 +: IDX_W]),
        .tag_i     (pc_q[INST_ADDR_W-1 -: TAG_W]),
        .hit_o     (cache_hit),
        .rd_data_o (cache_data),
        .wr_en_i   (cache_wr_en),
        .wr_data_i (word_d)
    );

    // Word being assembled with the incoming byte merged into its lane.
    always_comb begin
        word_d = buf_q;
        word_d[{rcv_cnt_q[1:0], 3'b000} +: 8] = mem_rdata_i;
    end

    // Fetch FSM: redirect outranks everything, then lookup / refill / hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IF_LOOKUP;
            pc_q       <= RESET_PC;
            first_q    <= 1'b1;
            req_cnt_q  <= 3'd0;
            rcv_cnt_q  <= 3'd0;
            buf_q      <= ZERO_WORD;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            if_flag_q  <= 1'b0;
            if_first_q <= 1'b0;
            if_pc_q    <= '0;
            if_inst_q  <= ZERO_WORD;
        end else if (br_flag_i) begin
            pc_q       <= word_align(br_target_i);
            first_q    <= 1'b1;
            if_flag_q  <= 1'b0;
            if_first_q <= 1'b0;
            mem_req_q  <= 1'b0;
            req_cnt_q  <= 3'd0;
            rcv_cnt_q  <= 3'd0;
            state_q    <= IF_LOOKUP;
        end else begin
            case (state_q)
                IF_LOOKUP: begin
                    if (cache_hit) begin
                        if_flag_q  <= 1'b1;
                        if_first_q <= first_q;
                        if_pc_q    <= pc_q;
                        if_inst_q  <= cache_data;
                        state_q    <= IF_HOLD;
                    end else begin
                        req_cnt_q  <= 3'd0;
                        rcv_cnt_q  <= 3'd0;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= pc_q;
                        state_q    <= IF_FETCH;
                    end
                end
                IF_FETCH: begin
                    // Address advances only once the controller has taken it.
                    if (mem_req_q && mem_gnt_i) begin
                        req_cnt_q <= req_cnt_q + 3'd1;
                        if (req_cnt_q == 3'd3) begin
                            mem_req_q <= 1'b0;
                        end else begin
                            mem_addr_q <= pc_q + {29'd0, req_cnt_q + 3'd1};
                        end
                    end
                    if (mem_rvalid_i) begin
                        buf_q     <= word_d;
                        rcv_cnt_q <= rcv_cnt_q + 3'd1;
                        if (rcv_cnt_q == 3'd3) begin
                            if_flag_q  <= 1'b1;
                            if_first_q <= first_q;
                            if_pc_q    <= pc_q;
                            if_inst_q  <= word_d;
                            state_q    <= IF_HOLD;
                        end
                    end
                end
                IF_HOLD: begin
                    if (transfer) begin
                        pc_q       <= pc_q + 32'd4;
                        first_q    <= 1'b0;
                        if_flag_q  <= 1'b0;
                        if_first_q <= 1'b0;
                        state_q    <= IF_LOOKUP;
                    end
                end
                default: state_q <= IF_LOOKUP;
            endcase
        end
    end

    assign mem_req_o  = mem_req_q;
    assign mem_addr_o = mem_addr_q;
    assign if_flag_o  = if_flag_q;
    assign if_first_o = if_first_q;
    assign if_pc_o    = if_pc_q;
    assign if_inst_o  = if_inst_q;

endmodule
